// File: rtl/fifo_pkg.sv
// Shared types for the fifo read-side blocks: pacer FSM encoding and counter width.
// Combinational helpers only; no state lives here.
// Nothing in this package applies backpressure.
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_PAUSE = 2'd2
  } rd_state_t;

  localparam int CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rd_pacer.sv
// Read pacer: issues fifo reads in bursts of BURST accepts separated by PAUSE idle cycles.
// Latency: ren is combinational from state, enable and empty; state moves on each rclk edge.
// Backpressure: empty drops ren in the same cycle and stalls the burst without using up count.
module rd_pacer
  import fifo_pkg::*;
#(
  parameter int BURST = 4,
  parameter int PAUSE = 2
) (
  input  logic rclk,
  input  logic rst,
  input  logic enable,
  input  logic empty,
  output logic ren,
  output logic accept
);

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);
  localparam logic [7:0] PAUSE_LAST = 8'((PAUSE == 0) ? 0 : PAUSE - 1);

  rd_state_t  state, state_nxt;
  logic [7:0] bcnt, bcnt_nxt;
  logic [7:0] pcnt, pcnt_nxt;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      bcnt  <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      pcnt  <= pcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    pcnt_nxt  = pcnt;
    ren       = (state == ST_READ) && enable && !empty;
    // ren already excludes empty, so every ren cycle is an accepted read
    accept    = ren;

    if (!enable) begin
      state_nxt = ST_IDLE;
      bcnt_nxt  = '0;
      pcnt_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_READ;
        ST_READ: begin
          if (accept) begin
            if (bcnt == BURST_LAST) begin
              bcnt_nxt = '0;
              if (PAUSE != 0) state_nxt = ST_PAUSE;
            end else begin
              bcnt_nxt = bcnt + 8'd1;
            end
          end
        end
        ST_PAUSE: begin
          if (pcnt == PAUSE_LAST) begin
            pcnt_nxt  = '0;
            state_nxt = ST_READ;
          end else begin
            pcnt_nxt = pcnt + 8'd1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_checker.sv
// Paced fifo reader that checks each word against an incrementing reference.
// Latency: word accepted at edge N is compared and counted at edge N+1.
// Backpressure: reads stall while the fifo reports empty; the checker itself never stalls.
module fifo_rd_checker
  import fifo_pkg::*;
#(
  parameter int                D_SIZE = 8,
  parameter int                BURST  = 4,
  parameter int                PAUSE  = 2,
  parameter logic [D_SIZE-1:0] INIT   = '0
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [D_SIZE-1:0] rdata,
  output logic              ren,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err,
  output logic [D_SIZE-1:0] last_bad
);

  logic              accept;
  logic              vld_d;
  logic [D_SIZE-1:0] exp_dat;

  rd_pacer #(
    .BURST (BURST),
    .PAUSE (PAUSE)
  ) u_pacer (
    .rclk   (rclk),
    .rst    (rst),
    .enable (enable),
    .empty  (empty),
    .ren    (ren),
    .accept (accept)
  );

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      vld_d    <= 1'b0;
      exp_dat  <= INIT;
      rd_cnt   <= '0;
      err_cnt  <= '0;
      err      <= 1'b0;
      last_bad <= '0;
    end else begin
      vld_d <= accept;
      if (vld_d) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rdata == exp_dat) begin
          exp_dat <= exp_dat + 1'b1;
        end else begin
          // resync to the observed word so a single drop/dup costs one error
          err_cnt  <= sat_inc(err_cnt);
          err      <= 1'b1;
          last_bad <= rdata;
          exp_dat  <= rdata + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Directed bench: a queue stands in for the registered-output fifo; per-cycle vector tables
// plus hand-written sequences for reset, wrap-around and error-count saturation.
module tb_fifo_rd_checker;

  logic        rclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0, empty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        ren;
  logic [15:0] rd_cnt, err_cnt;
  logic        err;
  logic [7:0]  last_bad;

  logic        enable2 = 1'b0, empty2 = 1'b1;
  logic [7:0]  rdata2 = 8'h00;
  logic        ren2;
  logic [15:0] rd_cnt2, err_cnt2;
  logic        err2;
  logic [7:0]  last_bad2;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];

  typedef struct {
    logic        en;
    logic        push;
    logic [7:0]  pdat;
    logic        ren;
    logic [15:0] rd;
    logic [15:0] ec;
    logic        e;
    logic [7:0]  bad;
  } vec_t;
  vec_t vecs[$];

  always #5 rclk = ~rclk;

  fifo_rd_checker dut (
    .rclk(rclk), .rst(rst), .enable(enable), .empty(empty), .rdata(rdata),
    .ren(ren), .rd_cnt(rd_cnt), .err_cnt(err_cnt), .err(err), .last_bad(last_bad)
  );

  fifo_rd_checker #(.D_SIZE(8), .BURST(255), .PAUSE(0), .INIT(8'hFE)) dut2 (
    .rclk(rclk), .rst(rst), .enable(enable2), .empty(empty2), .rdata(rdata2),
    .ren(ren2), .rd_cnt(rd_cnt2), .err_cnt(err_cnt2), .err(err2), .last_bad(last_bad2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic add(input logic en, input logic push, input logic [7:0] pdat, input logic r,
                     input logic [15:0] rd, input logic [15:0] ec, input logic e,
                     input logic [7:0] bad);
    vec_t v;
    v.en = en; v.push = push; v.pdat = pdat; v.ren = r;
    v.rd = rd; v.ec = ec; v.e = e; v.bad = bad;
    vecs.push_back(v);
  endtask

  task automatic addc(input logic en, input logic r, input logic [15:0] rd);
    add(en, 1'b0, 8'h00, r, rd, 16'h0, 1'b0, 8'h00);
  endtask

  task automatic addp(input logic [7:0] pdat, input logic r, input logic [15:0] rd);
    add(1'b1, 1'b1, pdat, r, rd, 16'h0, 1'b0, 8'h00);
  endtask

  // Called at a negedge: fifo model pops on an accepted read, output appears after the edge.
  task automatic finish_cycle();
    logic acc;
    acc = ren && !empty;
    @(posedge rclk);
    #1;
    if (acc) rdata = q.pop_front();
    empty = (q.size() == 0);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge rclk);
      finish_cycle();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0; enable2 = 1'b0;
    empty = 1'b1;  empty2 = 1'b1;
    rdata = 8'h00; rdata2 = 8'h00;
    q.delete();
    repeat (2) @(posedge rclk);
    #1 rst = 1'b0;
  endtask

  task automatic preload(input int first, input int n);
    for (int k = 0; k < n; k++) q.push_back(8'(first + k));
  endtask

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      enable = vecs[i].en;
      if (vecs[i].push) q.push_back(vecs[i].pdat);
      empty = (q.size() == 0);
      @(negedge rclk);
      chk($sformatf("%s[%0d].ren", tag, i), 32'(ren), 32'(vecs[i].ren));
      chk($sformatf("%s[%0d].rd_cnt", tag, i), 32'(rd_cnt), 32'(vecs[i].rd));
      chk($sformatf("%s[%0d].err_cnt", tag, i), 32'(err_cnt), 32'(vecs[i].ec));
      chk($sformatf("%s[%0d].err", tag, i), 32'(err), 32'(vecs[i].e));
      chk($sformatf("%s[%0d].last_bad", tag, i), 32'(last_bad), 32'(vecs[i].bad));
      finish_cycle();
    end
    vecs.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state of both instances
    do_reset();
    enable = 1'b1;
    empty  = 1'b0;
    @(negedge rclk);
    chk("rst.ren", 32'(ren), 32'h0);
    chk("rst.rd_cnt", 32'(rd_cnt), 32'h0);
    chk("rst.err_cnt", 32'(err_cnt), 32'h0);
    chk("rst.err", 32'(err), 32'h0);
    chk("rst.last_bad", 32'(last_bad), 32'h0);
    chk("rst.rd_cnt2", 32'(rd_cnt2), 32'h0);
    chk("rst.err2", 32'(err2), 32'h0);

    // clean stream 0..9: ren 4 high, 2 low, 4 high, 2 low, 2 high
    do_reset();
    preload(0, 10);
    addc(1, 0, 0);  addc(1, 1, 0);  addc(1, 1, 0);  addc(1, 1, 1);
    addc(1, 1, 2);  addc(1, 0, 3);  addc(1, 0, 4);  addc(1, 1, 4);
    addc(1, 1, 4);  addc(1, 1, 5);  addc(1, 1, 6);  addc(1, 0, 7);
    addc(1, 0, 8);  addc(1, 1, 8);  addc(1, 1, 8);  addc(1, 0, 9);
    addc(1, 0, 10);
    run_table("clean");

    // empty stall: 2 words, 3 empty cycles, 2 more; a word pushed during the pause must wait
    do_reset();
    preload(0, 2);
    addc(1, 0, 0);  addc(1, 1, 0);  addc(1, 1, 0);  addc(1, 0, 1);
    addc(1, 0, 2);  addc(1, 0, 2);  addp(8'd2, 1, 2); addp(8'd3, 1, 2);
    addp(8'd4, 0, 3); addc(1, 0, 4); addc(1, 1, 4);  addc(1, 0, 4);
    addc(1, 0, 5);
    run_table("stall");

    // dropped word: 0,1,2,4,5 gives exactly one error on 4
    do_reset();
    q.push_back(8'd0); q.push_back(8'd1); q.push_back(8'd2);
    q.push_back(8'd4); q.push_back(8'd5);
    addc(1, 0, 0);  addc(1, 1, 0);  addc(1, 1, 0);  addc(1, 1, 1);
    addc(1, 1, 2);  addc(1, 0, 3);
    add(1, 0, 8'h00, 0, 16'd4, 16'd1, 1, 8'h04);
    add(1, 0, 8'h00, 1, 16'd4, 16'd1, 1, 8'h04);
    add(1, 0, 8'h00, 0, 16'd4, 16'd1, 1, 8'h04);
    add(1, 0, 8'h00, 0, 16'd5, 16'd1, 1, 8'h04);
    run_table("drop");

    // enable drop: pending sample still checked, re-enable starts a fresh 4-read burst
    do_reset();
    preload(0, 6);
    addc(1, 0, 0);  addc(1, 1, 0);  addc(1, 1, 0);  addc(0, 0, 1);
    addc(0, 0, 2);  addc(1, 0, 2);  addc(1, 1, 2);  addc(1, 1, 2);
    addc(1, 1, 3);  addc(1, 1, 4);  addp(8'd6, 0, 5); addc(1, 0, 6);
    addc(1, 1, 6);  addc(1, 0, 6);  addc(1, 0, 7);
    run_table("endrop");

    // reset while a sample is pending; next word must be compared against INIT
    do_reset();
    q.push_back(8'd9); q.push_back(8'd10);
    empty  = 1'b0;
    enable = 1'b1;
    run_cycles(3);
    @(negedge rclk);
    chk("midrst.pre_err", 32'(err), 32'h1);
    chk("midrst.pre_err_cnt", 32'(err_cnt), 32'h1);
    chk("midrst.pre_last_bad", 32'(last_bad), 32'h09);
    chk("midrst.pre_rd_cnt", 32'(rd_cnt), 32'h1);
    rst = 1'b1;
    #1;
    chk("midrst.ren", 32'(ren), 32'h0);
    chk("midrst.rd_cnt", 32'(rd_cnt), 32'h0);
    chk("midrst.err_cnt", 32'(err_cnt), 32'h0);
    chk("midrst.err", 32'(err), 32'h0);
    chk("midrst.last_bad", 32'(last_bad), 32'h0);
    @(posedge rclk);
    #1;
    rst = 1'b0;
    q.delete();
    q.push_back(8'd0);
    empty = 1'b0;
    run_cycles(3);
    @(negedge rclk);
    chk("midrst.post_rd_cnt", 32'(rd_cnt), 32'h1);
    chk("midrst.post_err_cnt", 32'(err_cnt), 32'h0);
    chk("midrst.post_err", 32'(err), 32'h0);

    // wrap-around on the second instance: INIT=FE, data FE,FF,00,01, continuous reads
    do_reset();
    begin
      logic [7:0] wrap[4];
      wrap[0] = 8'hFE; wrap[1] = 8'hFF; wrap[2] = 8'h00; wrap[3] = 8'h01;
      enable2 = 1'b1;
      empty2  = 1'b0;
      @(posedge rclk);
      #1;
      for (int i = 0; i < 4; i++) begin
        @(negedge rclk);
        chk($sformatf("wrap[%0d].ren2", i), 32'(ren2), 32'h1);
        @(posedge rclk);
        #1;
        rdata2 = wrap[i];
        if (i == 3) empty2 = 1'b1;
      end
    end
    @(negedge rclk);
    chk("wrap.ren2_empty", 32'(ren2), 32'h0);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("wrap.rd_cnt2", 32'(rd_cnt2), 32'd4);
    chk("wrap.err_cnt2", 32'(err_cnt2), 32'h0);
    chk("wrap.err2", 32'(err2), 32'h0);

    // saturation: a constant word mismatches every time; drive err_cnt to FFFE, then 3 more
    @(posedge rclk);
    #1;
    rdata2 = 8'h55;
    empty2 = 1'b0;
    repeat (65534) @(posedge rclk);
    #1 empty2 = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("sat.err_cnt2_fffe", 32'(err_cnt2), 32'hFFFE);
    chk("sat.rd_cnt2_wrap", 32'(rd_cnt2), 32'd2);
    chk("sat.err2", 32'(err2), 32'h1);
    chk("sat.last_bad2", 32'(last_bad2), 32'h55);
    @(posedge rclk);
    #1 empty2 = 1'b0;
    repeat (3) @(posedge rclk);
    #1 empty2 = 1'b1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("sat.err_cnt2_ffff", 32'(err_cnt2), 32'hFFFF);
    chk("sat.rd_cnt2", 32'(rd_cnt2), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_checker.md
# fifo_rd_checker

Synthesizable read-side consumer for the dual-clock `fifo`, sitting in the read-clock domain opposite the `send` write-side stimulus. It paces reads in bursts of `BURST` accepted reads separated by `PAUSE` idle cycles, and checks every read word against an incrementing reference sequence. It reports read and error counts, a sticky error flag and the last bad word, and can serve as a self-checking receiver in benches or as a built-in data-path monitor.

## Interface
- `D_SIZE`, 8, data width; must match `fifo`.
- `BURST`, 4, accepted reads per burst; legal range 1..255.
- `PAUSE`, 2, idle cycles between bursts; legal range 0..255; 0 means continuous reading.
- `INIT`, 0, first expected data value.
- `rclk`  input  1  read clock; all state is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `enable`  input  1  run request; 0 parks the block in IDLE.
- `empty`  input  1  `fifo` empty flag, in the `rclk` domain.
- `rdata`  input  D_SIZE  `fifo` read data.
- `ren`  output  1  read enable to `fifo`.
- `rd_cnt`  output  16  number of checked words; wraps modulo 2^16.
- `err_cnt`  output  16  number of mismatches; saturates at 16'hFFFF.
- `err`  output  1  sticky mismatch flag.
- `last_bad`  output  D_SIZE  `rdata` value of the most recent mismatch.

## Operation
- **Accepted read:** `ren`=1 and `empty`=0 at a `rclk` rising edge. That entry appears on `rdata` in the following cycle (registered `fifo` output).
- **`ren` logic:** combinational, `ren = (state==READ) && enable && !empty`. `ren` is never asserted while `empty`=1.
- **FSM states:** IDLE, READ, PAUSE.
  - IDLE → READ when `enable`=1.
  - READ: a burst counter increments on each accepted read. On the accepted read that brings the count to `BURST`, the counter clears and the state goes to PAUSE, or stays in READ if `PAUSE`=0.
  - PAUSE: the pause counter counts `PAUSE` cycles, then the state returns to READ.
  - Any state → IDLE on a cycle with `enable`=0. The burst and pause counters clear. Re-enabling starts a fresh burst.
- **Checker pipeline:** `vld_d` is a register set one cycle after each accepted read. On a cycle with `vld_d`=1:
  - `rd_cnt` increments.
  - Match (`rdata==exp`): `exp` becomes `exp+1`, modulo 2^D_SIZE (wraps from all-ones to 0).
  - Mismatch: `err_cnt` increments with saturation, `err` is set, `last_bad` captures `rdata`, and `exp` resyncs to `rdata+1`. A single dropped or duplicated entry therefore costs exactly one error.
- **Pending sample:** a read accepted just before `enable` falls is still checked in the next cycle.
- **Reset values (async, any time):** `ren`=0 (state IDLE), `rd_cnt`=0, `err_cnt`=0, `err`=0, `last_bad`=0, `exp`=INIT, `vld_d`=0, burst and pause counters 0. A pending sample is discarded.

## Timing
- **Latency:** accepted read at edge N; compare and counter update at edge N+1.
- **Throughput:** one read per cycle inside a burst.
- **Burst period:** a full burst with data always available takes `BURST`+`PAUSE` cycles.
- **`empty` during a burst:** stalls without consuming burst count. The FSM stays in READ and `ren` drops in the same cycle.
- **Counter updates:** `rd_cnt` and `err_cnt` update registered, one cycle after the accepted read.
- **`err`:** rises in the cycle after the mismatching sample is on `rdata`. Only `rst` clears it.
- **Edge cases:** `enable` and `empty` changing in the same cycle is legal; `ren` follows the combinational equation.

## Structure
- **Shared package `fifo_pkg`:** FSM state encodings (IDLE=2'd0, READ=2'd1, PAUSE=2'd2) and the 16-bit counter-width constant. `D_SIZE` defaults stay as module parameters.
- **Sub-module `rd_pacer`:** FSM, burst/pause counters and `ren` generation, with inputs `enable` and `empty` and outputs `ren` and an accept pulse.
- **`fifo_rd_checker`:** instantiates `rd_pacer` and holds `vld_d`, `exp` and the counters.

## Test plan
- **Reset mid-operation:** assert `rst` while `vld_d`=1 → all outputs return to reset values immediately, and the next checked word is compared against INIT.
- **Clean stream:** `fifo` preloaded with 0..9, `BURST`=4, `PAUSE`=2, `enable`=1 → `ren` high 4 cycles, low 2, high 4, low 2, high 2. `rd_cnt`=10, `err_cnt`=0, `err`=0.
- **Empty stall:** `fifo` holds 2 words then goes empty for 3 cycles, then receives 2 more → `ren` low during the empty cycles, FSM stays in READ, the burst completes after the 4th accepted read, and no errors.
- **Dropped word:** sequence 0,1,2,4,5 → exactly one error: `err_cnt`=1, `last_bad`=8'h04, `err`=1, and 5 is checked OK.
- **Wrap-around:** `INIT`=8'hFE, data FE,FF,00,01 → `err_cnt`=0 and `rd_cnt`=4.
- **Saturation:** force `err_cnt` to 16'hFFFE, then inject 3 mismatches → `err_cnt` holds at 16'hFFFF.
